rampa_pwm_driver: RTL and testbench
===================================

Name: rampa_pwm_driver

Overview:
- Downstream stage of the soft-start ramp FSM.
- Consumes the FSM's one-hot speed-level flags (30 %, 50 %, 100 %) and turns them into a slew-limited duty cycle.
- Produces a glitch-free 100-step PWM output for the motor driver pin on uo_out.
- Also reports ramp status and illegal-level faults for debug pins.

Parameters:
- PERIOD, 100, PWM clocks per period; duty is expressed directly in percent.
- SLEW_DIV, 100000, clocks between duty steps (one slew tick); minimum 2.
- STEP, 1, duty change per slew tick in percent; must divide 30, 50 and 100.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; low forces a safe-off state
- level_30  input  1  request 30 % duty (from ramp FSM)
- level_50  input  1  request 50 % duty
- level_100  input  1  request 100 % duty
- pwm_out  output  1  PWM drive, registered
- duty  output  7  current slewed duty in percent, 0..100
- at_target  output  1  high when duty equals the decoded target and state is HOLD
- fault  output  1  illegal level combination seen; sticky until cleared
- state  output  3  FSM state code for debug

Behaviour:
- Reset (rst_n=0, async): all registers 0; pwm_out=0, duty=0, at_target=0, fault=0, state=IDLE.
- Input register: level_* captured every clk into lvl_q; all decoding uses lvl_q, so there is 1 cycle of input latency.
- Target decode from lvl_q:
  - none high -> 0
  - only level_30 -> 30
  - only level_50 -> 50
  - only level_100 -> 100
  - two or more high -> illegal, target 0.
- Slew tick: tick_cnt counts 0..SLEW_DIV-1 and wraps; tick is a 1-cycle pulse when tick_cnt==SLEW_DIV-1.
- FSM states (codes): IDLE=0, RAMP_UP=1, RAMP_DOWN=2, HOLD=3, FAULT=4.
  - Any state, illegal lvl_q -> FAULT on the next edge. duty is cleared to 0 in that same edge (no slewing) and fault is set.
  - IDLE (duty=0): target>0 -> RAMP_UP.
  - RAMP_UP: on tick, duty+=STEP, with the result clamped to target. duty==target -> HOLD. target<duty -> RAMP_DOWN.
  - RAMP_DOWN: on tick, duty-=STEP, clamped to target. duty==target -> HOLD, or IDLE if target==0. target>duty -> RAMP_UP.
  - HOLD: target>duty -> RAMP_UP; target<duty -> RAMP_DOWN. If target==duty, stay.
  - FAULT: duty held at 0. Exit to IDLE only after lvl_q=000 for one complete PWM period (PERIOD consecutive cycles). fault clears on that exit.
- Duty updates only on tick cycles; between ticks duty is stable.
- PWM counter and duty latch:
  - pwm_cnt counts 0..PERIOD-1 and wraps.
  - duty_active loads duty when pwm_cnt==PERIOD-1, so a new duty takes effect at the next period start. The only exception is FAULT entry, which loads duty_active=0 immediately.
- PWM output:
  - pwm_out <= (pwm_cnt < duty_active), registered, 1-cycle lag.
  - duty 0 gives constant low; duty 100 gives constant high with no period-boundary glitch.
- Target change mid-ramp: direction reverses on the next edge. The duty value is never reset.
- ena=0 (synchronous): tick_cnt, pwm_cnt, duty, duty_active and pwm_out go to 0 and state goes to IDLE. fault is preserved. When ena returns high, the block restarts from IDLE.
- Reset asserted mid-ramp: pwm_out goes low asynchronously, and the block restarts from IDLE after release.
- Arithmetic: duty is 7-bit unsigned. Clamping guarantees the range 0..100, with no underflow below 0 and no overflow above target.

Decomposition:
- Shared package rampa_pkg holds:
  - state enum
  - duty constants DUTY_30=30, DUTY_50=50, DUTY_100=100
  - DUTY_W=7
  - the one-hot level-to-target decode function, reused by the ramp FSM's checks.
- One natural sub-module: rampa_pwm_gen. It contains pwm_cnt, the duty_active latch and pwm_out, and has ports clk, rst_n, clr, load_now, duty, pwm_out.
- Slewing FSM and tick counter stay in the top module.

Test Plan:
All scenarios use SLEW_DIV=4, STEP=1.
- Ramp up: reset released, then level_50=1 held. Required: state=RAMP_UP; duty increments every 4 clks; duty=50 after 50 ticks; state=HOLD; at_target=1. In the next full period, pwm_out is high for exactly 50 of 100 clks.
- Full speed: from HOLD at 50, level_50=0 and level_100=1. Required: duty slews 50->100 in 50 ticks. Once duty_active=100, pwm_out stays high continuously across at least 3 period boundaries.
- Ramp down: from 100, switch to level_30 only. Required: state=RAMP_DOWN; duty 100->30 in 70 ticks; HOLD; pwm_out high 30/100 clks per period.
- Illegal input: during HOLD at 50, drive level_30=1 and level_50=1. Required:
  - duty=0 and fault=1 two edges after the stimulus (input register, then FSM);
  - pwm_out=0 one edge later;
  - state=4.
  - Then all levels low for 100 clks -> IDLE, fault=0.
- Async reset: assert rst_n=0 mid-ramp at duty=23, between clock edges. Required: pwm_out, duty and state are 0 immediately, without a clock edge. After release with level_30=1, the ramp restarts from 0.
- Enable drop: ena=0 for 10 clks at duty=30. Required: pwm_out=0, duty=0, state=IDLE, fault unchanged. After ena=1, the ramp back to 30 completes in 30 ticks.

Source files
------------

// File: rtl/rampa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rampa_pkg
// Purpose  : Shared types and constants for the soft-start PWM driver.
//            Holds the FSM state encoding, duty constants, and the one-hot
//            level-flag decode used by the slewing FSM.
// Contents : state_e, level_dec_t, DUTY_W, DUTY_30/50/100, decode_level()
// Revision : 1.0 - initial release
// ============================================================================
package rampa_pkg;

    localparam int DUTY_W = 7;

    localparam logic [DUTY_W-1:0] DUTY_30  = 7'd30;
    localparam logic [DUTY_W-1:0] DUTY_50  = 7'd50;
    localparam logic [DUTY_W-1:0] DUTY_100 = 7'd100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_HOLD      = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    typedef struct packed {
        logic              illegal;
        logic [DUTY_W-1:0] target;
    } level_dec_t;

    // lvl bit order is {level_100, level_50, level_30}. More than one flag
    // high is illegal and decodes to a zero target.
    function automatic level_dec_t decode_level(input logic [2:0] lvl);
        level_dec_t d;
        d.illegal = 1'b0;
        d.target  = '0;
        case (lvl)
            3'b000:  d.target  = '0;
            3'b001:  d.target  = DUTY_30;
            3'b010:  d.target  = DUTY_50;
            3'b100:  d.target  = DUTY_100;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rampa_pwm_driver_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : rampa_pwm_gen
// Purpose  : Period counter, period-aligned duty latch and registered PWM
//            output. A new duty is picked up at the end of each period so
//            the output never glitches mid-period; load_now forces an
//            immediate load (used to kill the output on a fault).
// Ports    : clk, rst_n (async, active-low), clr (sync clear to off),
//            load_now (load duty immediately), duty (percent), pwm_out
// Revision : 1.0 - initial release
// ============================================================================
module rampa_pwm_gen
    import rampa_pkg::*;
#(
    parameter int PERIOD = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_now,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out
);

    localparam int                CNT_W      = $clog2(PERIOD);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0]  r_pwm_cnt;
    logic [DUTY_W-1:0] r_duty_active;
    logic              r_pwm_out;
    logic              w_wrap;

    assign w_wrap = (r_pwm_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt     <= '0;
            r_duty_active <= '0;
            r_pwm_out     <= 1'b0;
        end else if (clr) begin
            r_pwm_cnt     <= '0;
            r_duty_active <= '0;
            r_pwm_out     <= 1'b0;
        end else begin
            r_pwm_cnt <= w_wrap ? '0 : r_pwm_cnt + CNT_W'(1);
            if (load_now || w_wrap) begin
                r_duty_active <= duty;
            end
            // A duty of PERIOD keeps this true for every count, so full
            // speed stays high straight across period boundaries.
            r_pwm_out <= (int'(r_pwm_cnt) < int'(r_duty_active));
        end
    end

    assign pwm_out = r_pwm_out;

endmodule
`default_nettype wire

// File: rtl/rampa_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : rampa_pwm_driver
// Purpose  : Turns the ramp FSM's one-hot speed flags into a slew-limited
//            duty cycle and a glitch-free PWM drive, with fault detection
//            for illegal flag combinations.
// Ports    : clk, rst_n (async, active-low), ena (sync enable),
//            level_30/50/100 (requested speed), pwm_out (PWM drive),
//            duty (current duty %), at_target, fault (sticky), state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module rampa_pwm_driver
    import rampa_pkg::*;
#(
    parameter int PERIOD   = 100,
    parameter int SLEW_DIV = 100000,
    parameter int STEP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              level_30,
    input  logic              level_50,
    input  logic              level_100,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target,
    output logic              fault,
    output logic [2:0]        state
);

    localparam int                 TICK_W      = $clog2(SLEW_DIV);
    localparam int                 ZERO_W      = $clog2(PERIOD);
    localparam logic [TICK_W-1:0]  c_tick_last = TICK_W'(SLEW_DIV - 1);
    localparam logic [ZERO_W-1:0]  c_zero_last = ZERO_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0]  c_step      = DUTY_W'(STEP);

    logic [2:0]        r_lvl_q;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    state_e            r_state;
    state_e            w_next_move;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_duty_slew;
    logic [DUTY_W-1:0] w_target;
    logic [DUTY_W-1:0] w_pwm_duty;
    logic [DUTY_W:0]   w_up_sum;
    logic              w_illegal;
    logic              w_fault_entry;
    logic              r_fault;
    logic [ZERO_W-1:0] r_zero_cnt;
    level_dec_t        w_dec;

    // Input register: all decoding works on the registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_q <= '0;
        end else begin
            r_lvl_q <= {level_100, level_50, level_30};
        end
    end

    assign w_dec     = decode_level(r_lvl_q);
    assign w_target  = w_dec.target;
    assign w_illegal = w_dec.illegal;

    // Slew tick divider
    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (!ena || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // One slew step toward the target, clamped so it never overshoots.
    // The extra sum bit keeps duty+STEP from wrapping near the top.
    assign w_up_sum = {1'b0, r_duty} + {1'b0, c_step};

    always_comb begin
        w_duty_slew = r_duty;
        if (w_tick) begin
            if (r_state == ST_RAMP_UP && r_duty < w_target) begin
                w_duty_slew = (w_up_sum >= {1'b0, w_target}) ? w_target
                                                             : w_up_sum[DUTY_W-1:0];
            end else if (r_state == ST_RAMP_DOWN && r_duty > w_target) begin
                w_duty_slew = ((r_duty - w_target) <= c_step) ? w_target
                                                               : (r_duty - c_step);
            end
        end
    end

    // Direction after this edge's step; reaching a zero target means idle.
    always_comb begin
        if (w_duty_slew < w_target) begin
            w_next_move = ST_RAMP_UP;
        end else if (w_duty_slew > w_target) begin
            w_next_move = ST_RAMP_DOWN;
        end else if (w_target == '0) begin
            w_next_move = ST_IDLE;
        end else begin
            w_next_move = ST_HOLD;
        end
    end

    assign w_fault_entry = ena && w_illegal;

    // Slewing FSM. Fault exit needs PERIOD consecutive all-low cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_duty     <= '0;
            r_fault    <= 1'b0;
            r_zero_cnt <= '0;
        end else if (!ena) begin
            r_state    <= ST_IDLE;
            r_duty     <= '0;
            r_zero_cnt <= '0;
        end else if (w_illegal) begin
            r_state    <= ST_FAULT;
            r_duty     <= '0;
            r_fault    <= 1'b1;
            r_zero_cnt <= '0;
        end else if (r_state == ST_FAULT) begin
            r_duty <= '0;
            if (r_lvl_q != 3'b000) begin
                r_zero_cnt <= '0;
            end else if (r_zero_cnt == c_zero_last) begin
                r_state    <= ST_IDLE;
                r_fault    <= 1'b0;
                r_zero_cnt <= '0;
            end else begin
                r_zero_cnt <= r_zero_cnt + ZERO_W'(1);
            end
        end else begin
            r_duty  <= w_duty_slew;
            r_state <= w_next_move;
        end
    end

    // On fault entry the latch is loaded with zero in the same edge, so
    // the output is dead one edge later instead of at the period end.
    assign w_pwm_duty = w_fault_entry ? '0 : r_duty;

    rampa_pwm_gen #(
        .PERIOD (PERIOD)
    ) u_pwm_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!ena),
        .load_now (w_fault_entry),
        .duty     (w_pwm_duty),
        .pwm_out  (pwm_out)
    );

    assign duty      = r_duty;
    assign fault     = r_fault;
    assign state     = r_state;
    assign at_target = (r_state == ST_HOLD) && (r_duty == w_target);

endmodule
`default_nettype wire

// File: tb/tb_rampa_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rampa_pwm_driver
// Purpose  : Self-checking bench for rampa_pwm_driver (SLEW_DIV=4, STEP=1).
//            A percent-level reference model predicts every output each
//            cycle; a vector table and hand sequences check the ramp,
//            fault, reset and enable scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rampa_pwm_driver;

    localparam int PERIOD   = 100;
    localparam int SLEW_DIV = 4;
    localparam int STEP     = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic       l30   = 1'b0;
    logic       l50   = 1'b0;
    logic       l100  = 1'b0;
    logic       pwm_out;
    logic [6:0] duty;
    logic       at_target;
    logic       fault;
    logic [2:0] state;

    rampa_pwm_driver #(
        .PERIOD   (PERIOD),
        .SLEW_DIV (SLEW_DIV),
        .STEP     (STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .level_30  (l30),
        .level_50  (l50),
        .level_100 (l100),
        .pwm_out   (pwm_out),
        .duty      (duty),
        .at_target (at_target),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers, percent units)
    int q30, q50, q100;
    int m_tick, m_state, m_duty, m_fault, m_zero, m_pcnt, m_dact, m_pwm;

    function automatic int tgt_of(input int a, input int b, input int c);
        if (a + b + c > 1) return 0;
        return 30 * a + 50 * b + 100 * c;
    endfunction

    task automatic model_reset();
        q30 = 0; q50 = 0; q100 = 0;
        m_tick = 0; m_state = 0; m_duty = 0; m_fault = 0;
        m_zero = 0; m_pcnt = 0; m_dact = 0; m_pwm = 0;
    endtask

    task automatic model_edge(input int e, input int a, input int b, input int c);
        int t, nd, new_dact;
        bit ill, tick;
        t    = tgt_of(q30, q50, q100);
        ill  = (q30 + q50 + q100) > 1;
        tick = (m_tick == SLEW_DIV - 1);
        if (e == 0) begin
            m_tick = 0; m_pcnt = 0; m_dact = 0; m_pwm = 0;
            m_duty = 0; m_state = 0; m_zero = 0;
        end else begin
            m_pwm    = (m_pcnt < m_dact) ? 1 : 0;
            new_dact = (m_pcnt == PERIOD - 1) ? m_duty : m_dact;
            if (ill) begin
                m_state = 4; m_duty = 0; m_fault = 1; m_zero = 0; new_dact = 0;
            end else if (m_state == 4) begin
                m_duty = 0;
                if (q30 + q50 + q100 == 0) begin
                    if (m_zero + 1 >= PERIOD) begin
                        m_state = 0; m_fault = 0; m_zero = 0;
                    end else begin
                        m_zero = m_zero + 1;
                    end
                end else begin
                    m_zero = 0;
                end
            end else begin
                nd = m_duty;
                if (tick && m_state == 1 && m_duty < t)
                    nd = (m_duty + STEP > t) ? t : m_duty + STEP;
                if (tick && m_state == 2 && m_duty > t)
                    nd = (m_duty - STEP < t) ? t : m_duty - STEP;
                m_duty = nd;
                if (nd < t)       m_state = 1;
                else if (nd > t)  m_state = 2;
                else if (t == 0)  m_state = 0;
                else              m_state = 3;
            end
            m_dact = new_dact;
            m_pcnt = (m_pcnt + 1) % PERIOD;
            m_tick = (m_tick + 1) % SLEW_DIV;
        end
        q30 = a; q50 = b; q100 = c;
    endtask

    task automatic check_model();
        int exp_at;
        exp_at = (m_state == 3 && m_duty == tgt_of(q30, q50, q100)) ? 1 : 0;
        checks++;
        if (pwm_out !== 1'(m_pwm) || duty !== 7'(m_duty) || at_target !== 1'(exp_at) ||
            fault !== 1'(m_fault) || state !== 3'(m_state)) begin
            errors++;
            $display("FAIL model t=%0t: got pwm=%0d duty=%0d at=%0d fault=%0d state=%0d required pwm=%0d duty=%0d at=%0d fault=%0d state=%0d",
                     $time, pwm_out, duty, at_target, fault, state,
                     m_pwm, m_duty, exp_at, m_fault, m_state);
        end
    endtask

    task automatic expect_val(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Drive inputs between edges, advance one clock, update and compare.
    task automatic step(input logic e, input logic a, input logic b, input logic c);
        ena = e; l30 = a; l50 = b; l100 = c;
        @(posedge clk);
        model_edge(e, a, b, c);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        ena = 1'b0; l30 = 1'b0; l50 = 1'b0; l100 = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic  e, a, b, c;
        int    cycles;
        int    exp_duty;
        int    exp_state;
        int    exp_at;
        int    exp_fault;
        string nm;
    } vec_t;

    vec_t tbl[10];
    int   prev, first_chg, last_chg, nchg, bad, high, exit_at, done_at, saved_fault;
    bit   found;
    int   sel, len, en, ra, rb, rc;

    initial begin
        tbl[0] = '{1, 0, 1, 0,   2,   0, 1, 0, 0, "start_up"};
        tbl[1] = '{1, 0, 1, 0, 250,  50, 3, 1, 0, "hold50"};
        tbl[2] = '{1, 0, 0, 1, 250, 100, 3, 1, 0, "hold100"};
        tbl[3] = '{1, 1, 0, 0, 320,  30, 3, 1, 0, "hold30"};
        tbl[4] = '{1, 0, 0, 0, 150,   0, 0, 0, 0, "back_idle"};
        tbl[5] = '{1, 1, 1, 0,   3,   0, 4, 0, 1, "fault_in"};
        tbl[6] = '{1, 0, 0, 0,  50,   0, 4, 0, 1, "fault_wait"};
        tbl[7] = '{1, 0, 0, 0,  60,   0, 0, 0, 0, "fault_exit"};
        tbl[8] = '{0, 0, 1, 0,  10,   0, 0, 0, 0, "ena_off"};
        tbl[9] = '{1, 0, 0, 1,   2,   0, 1, 0, 0, "restart"};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_val("reset_pwm",   pwm_out,   0);
        expect_val("reset_duty",  duty,      0);
        expect_val("reset_state", state,     0);
        expect_val("reset_fault", fault,     0);
        expect_val("reset_at",    at_target, 0);
        rst_n = 1'b1;

        // Vector table
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < tbl[v].cycles; k++)
                step(tbl[v].e, tbl[v].a, tbl[v].b, tbl[v].c);
            expect_val({tbl[v].nm, "_duty"},  duty,      tbl[v].exp_duty);
            expect_val({tbl[v].nm, "_state"}, state,     tbl[v].exp_state);
            expect_val({tbl[v].nm, "_at"},    at_target, tbl[v].exp_at);
            expect_val({tbl[v].nm, "_fault"}, fault,     tbl[v].exp_fault);
        end

        // Ramp up to 50: one step every SLEW_DIV clocks
        do_reset();
        first_chg = -1; last_chg = -1; nchg = 0; bad = 0;
        for (int i = 1; i <= 400; i++) begin
            prev = int'(duty);
            step(1, 0, 1, 0);
            if (i == 3) expect_val("rampup_state", state, 1);
            if (int'(duty) != prev) begin
                if (int'(duty) != prev + STEP) bad++;
                if (last_chg >= 0 && i - last_chg != SLEW_DIV) bad++;
                if (first_chg < 0) first_chg = i;
                last_chg = i;
                nchg++;
            end
        end
        expect_val("rampup_first_step", first_chg, 4);
        expect_val("rampup_bad_steps",  bad,       0);
        expect_val("rampup_steps",      nchg,      50);
        expect_val("rampup_last_step",  last_chg,  200);
        expect_val("rampup_hold",       state,     3);
        expect_val("rampup_at_target",  at_target, 1);
        high = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step(1, 0, 1, 0);
            high += int'(pwm_out);
        end
        expect_val("pwm_high_50", high, 50);

        // Full speed: constant high across period boundaries
        for (int i = 0; i < 400; i++) step(1, 0, 0, 1);
        expect_val("full_duty", duty, 100);
        high = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            step(1, 0, 0, 1);
            high += int'(pwm_out);
        end
        expect_val("pwm_high_100", high, 300);

        // Ramp down to 30
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        expect_val("rampdown_state", state, 2);
        for (int i = 0; i < 400; i++) step(1, 1, 0, 0);
        expect_val("rampdown_duty", duty,  30);
        expect_val("rampdown_hold", state, 3);
        high = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step(1, 1, 0, 0);
            high += int'(pwm_out);
        end
        expect_val("pwm_high_30", high, 30);

        // Illegal combination from HOLD at 50
        for (int i = 0; i < 400; i++) step(1, 0, 1, 0);
        expect_val("pre_fault_duty", duty, 50);
        step(1, 1, 1, 0);
        expect_val("fault_edge1_fault", fault, 0);
        step(1, 1, 1, 0);
        expect_val("fault_edge2_duty",  duty,  0);
        expect_val("fault_edge2_fault", fault, 1);
        expect_val("fault_edge2_state", state, 4);
        step(1, 0, 0, 0);
        expect_val("fault_edge3_pwm", pwm_out, 0);
        exit_at = -1;
        for (int i = 1; i <= 200; i++) begin
            step(1, 0, 0, 0);
            if (i == 99) expect_val("fault_sticky", fault, 1);
            if (exit_at < 0 && state == 3'd0) exit_at = i;
        end
        expect_val("fault_exit_cycles", exit_at, 100);
        expect_val("fault_cleared",     fault,   0);

        // Asynchronous reset mid-ramp at duty 23
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (!found) begin
                step(1, 1, 0, 0);
                if (duty == 7'd23) found = 1;
            end
        end
        expect_val("async_setup_reached", int'(found), 1);
        #3;
        rst_n = 1'b0;
        #1;
        expect_val("async_pwm",   pwm_out, 0);
        expect_val("async_duty",  duty,    0);
        expect_val("async_state", state,   0);
        model_reset();
        #2;
        rst_n = 1'b1;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        expect_val("async_restart_duty",  duty,  0);
        expect_val("async_restart_state", state, 1);
        for (int i = 0; i < 150; i++) step(1, 1, 0, 0);
        expect_val("async_reramp_duty", duty, 30);

        // Enable drop at duty 30
        saved_fault = int'(fault);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        expect_val("ena_off_pwm",   pwm_out, 0);
        expect_val("ena_off_duty",  duty,    0);
        expect_val("ena_off_state", state,   0);
        expect_val("ena_off_fault", fault,   saved_fault);
        done_at = -1;
        for (int i = 1; i <= 200; i++) begin
            step(1, 1, 0, 0);
            if (done_at < 0 && duty == 7'd30 && state == 3'd3) done_at = i;
        end
        expect_val("ena_reramp_cycles", done_at, 30 * SLEW_DIV);

        // Randomized segments against the reference model
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            en  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            len = $urandom_range(1, 150);
            ra = 0; rb = 0; rc = 0;
            case (sel)
                2:       ra = 1;
                3:       rb = 1;
                4, 5:    rc = 1;
                6: begin
                    ra = $urandom_range(0, 1);
                    rb = 1;
                    rc = (ra == 0) ? 1 : $urandom_range(0, 1);
                end
                7:       ra = 1;
                8:       rb = 1;
                default: ;
            endcase
            for (int k = 0; k < len; k++)
                step(1'(en), 1'(ra), 1'(rb), 1'(rc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
